// File: rtl/store_packer_if.sv
// Store request and memory write-port bundle for the store packer.
// No logic, no latency; pure signal grouping.
// Backpressure: req_ready throttles the producer, mem_ready throttles the packer.
interface store_packer_if #(
   parameter int ADDR_W    = 64,
   parameter int MEM_BYTES = 4
);
   logic                   req_valid;
   logic                   req_ready;
   logic [ADDR_W-1:0]      req_addr;
   logic [63:0]            req_data;
   logic [1:0]             req_size;

   logic                   mem_valid;
   logic                   mem_ready;
   logic [ADDR_W-1:0]      mem_addr;
   logic [8*MEM_BYTES-1:0] mem_wdata;
   logic [MEM_BYTES-1:0]   mem_wstrb;

   // Packer side: consumes requests, produces memory beats.
   modport slave (
      input  req_valid, req_addr, req_data, req_size, mem_ready,
      output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

   // Environment side: produces requests, accepts memory beats.
   modport master (
      output req_valid, req_addr, req_data, req_size, mem_ready,
      input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/store_packer.sv
// Truncates a 64-bit store value to 1/2/4/8 bytes and packs it into 1-3 byte-enabled word beats.
// Latency: first beat valid the cycle after accept; done pulses the cycle after the last beat handshake.
// Backpressure: beats hold stable while mem_ready is low; req_ready is high only in IDLE.
module store_packer #(
   parameter int MEM_BYTES = 4,
   parameter int ADDR_W    = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   store_packer_if.slave    bus,
   output logic             done,
   output logic             busy
);
   localparam int WORD_W = 8 * MEM_BYTES;

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t              state, stateNext;
   logic [1:0]          beatIdx;
   logic [1:0]          lastIdx;
   logic [ADDR_W-1:0]   baseAddr;
   logic [3*WORD_W-1:0] packData;
   logic [3*MEM_BYTES-1:0] packStrb;

   logic                accept;
   logic                beatFire;
   logic                lastBeat;
   logic [1:0]          offset;
   logic [3:0]          nBytes;
   logic [3:0]          endByte;
   logic [63:0]         keepMask;
   logic [7:0]          byteMask;
   logic [3*WORD_W-1:0] shiftedData;
   logic [3*MEM_BYTES-1:0] shiftedStrb;

   assign offset   = bus.req_addr[1:0];
   assign accept   = bus.req_valid && (state == IDLE);
   assign beatFire = (state == SEND) && bus.mem_ready;
   assign lastBeat = (beatIdx == lastIdx);

   // Decode the access size into byte count, data keep-mask and byte-enable mask.
   always_comb begin
      nBytes   = 4'd1;
      keepMask = 64'h0000_0000_0000_00FF;
      byteMask = 8'h01;
      case (bus.req_size)
         2'd0: begin nBytes = 4'd1; keepMask = 64'h0000_0000_0000_00FF; byteMask = 8'h01; end
         2'd1: begin nBytes = 4'd2; keepMask = 64'h0000_0000_0000_FFFF; byteMask = 8'h03; end
         2'd2: begin nBytes = 4'd4; keepMask = 64'h0000_0000_FFFF_FFFF; byteMask = 8'h0F; end
         default: begin nBytes = 4'd8; keepMask = 64'hFFFF_FFFF_FFFF_FFFF; byteMask = 8'hFF; end
      endcase
   end

   // Place the kept bytes at their final lane positions across a 3-word window;
   // the index of the last touched byte selects the final beat.
   assign shiftedData = {{(3*WORD_W-64){1'b0}}, bus.req_data & keepMask} << {offset, 3'b000};
   assign shiftedStrb = {{(3*MEM_BYTES-8){1'b0}}, byteMask} << offset;
   assign endByte     = {2'b00, offset} + nBytes - 4'd1;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= stateNext;
   end

   // Next-state logic and control outputs.
   always_comb begin
      stateNext     = state;
      bus.req_ready = 1'b0;
      bus.mem_valid = 1'b0;
      done          = 1'b0;
      busy          = 1'b1;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            busy          = 1'b0;
            if (accept) stateNext = SEND;
         end
         SEND: begin
            bus.mem_valid = 1'b1;
            if (beatFire && lastBeat) stateNext = DONE;
         end
         DONE: begin
            done      = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Capture the packed store on accept and step the beat index on each handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beatIdx  <= 2'd0;
         lastIdx  <= 2'd0;
         baseAddr <= '0;
         packData <= '0;
         packStrb <= '0;
      end else if (accept) begin
         beatIdx  <= 2'd0;
         lastIdx  <= endByte[3:2];
         baseAddr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
         packData <= shiftedData;
         packStrb <= shiftedStrb;
      end else if (beatFire && !lastBeat) begin
         beatIdx  <= beatIdx + 2'd1;
      end
   end

   // Beat payload is driven only while sending; all fields read zero otherwise.
   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wstrb = '0;
      if (state == SEND) begin
         bus.mem_addr = baseAddr + ADDR_W'({beatIdx, 2'b00});
         case (beatIdx)
            2'd0: begin
               bus.mem_wdata = packData[0 +: WORD_W];
               bus.mem_wstrb = packStrb[0 +: MEM_BYTES];
            end
            2'd1: begin
               bus.mem_wdata = packData[WORD_W +: WORD_W];
               bus.mem_wstrb = packStrb[MEM_BYTES +: MEM_BYTES];
            end
            default: begin
               bus.mem_wdata = packData[2*WORD_W +: WORD_W];
               bus.mem_wstrb = packStrb[2*MEM_BYTES +: MEM_BYTES];
            end
         endcase
      end
   end
endmodule

// File: doc/store_packer.md
Name: store_packer

Overview:
- Store-side counterpart of the load-path value extender.
- Takes a 64-bit register value plus an access size and truncates it to that size: no extension, only the low bytes are kept.
- Packs those bytes into byte-enabled beats on the 32-bit data-memory write port, splitting unaligned and 64-bit stores into 1–3 word beats.
- Sits between the execute stage's store request and the memory write interface.

Parameters:
- MEM_BYTES, 4, width of the memory data port in bytes. Only 4 is supported; other values are outside this block's scope.
- ADDR_W, 64, width of the address fields.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_addr  in  ADDR_W  byte address of the store; any alignment is allowed.
- req_data  in  64 (ulong_t)  register value; only the low size bytes are used.
- req_size  in  2 (sizeFlags_t)  BITS_8 / BITS_16 / BITS_32 / BITS_64 → 1 / 2 / 4 / 8 bytes.
- mem_valid  out  1  write beat valid.
- mem_ready  in  1  memory accepts the beat.
- mem_addr  out  ADDR_W  word-aligned beat address; bits [1:0] are always 0.
- mem_wdata  out  32  beat data; lanes with a strobe bit of 0 drive 0.
- mem_wstrb  out  4  byte-lane enables; bit i enables wdata[8i+7:8i].
- done  out  1  one-cycle pulse when the final beat has been accepted.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset, asynchronous and active-low: state = IDLE. req_ready=1; mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, done=0, busy=0.
- Reset mid-operation: mem_valid drops immediately and the partially sent store is abandoned. No done pulse is produced.
- Request acceptance:
  - A request is accepted on the edge where req_valid && req_ready.
  - The block captures off = addr[1:0], n = bytes(size), base = addr with bits [1:0] cleared, and the low 8 bytes of data.
  - Beat count = ceil((off+n)/4), which is 1, 2 or 3.
- Byte mapping:
  - Byte k (k = 0..n-1, where byte 0 is data[7:0]) goes to beat (off+k)/4 at lane (off+k)%4.
  - Beat j is sent at mem_addr = base + 4*j; address wrap at 2^ADDR_W is silent.
- States:
  - IDLE: req_ready=1. On accept, go to SEND with beat index 0. mem_valid rises on the cycle after accept, so the first beat has one cycle of latency.
  - SEND:
    - mem_valid=1. mem_addr, mem_wdata and mem_wstrb hold stable until mem_ready.
    - On mem_valid && mem_ready: if this is the last beat, go to DONE; otherwise advance the beat index and present the next beat on the following cycle.
    - Back-to-back beats are allowed when mem_ready is held high.
  - DONE: done=1 for exactly one cycle, mem_valid=0, then IDLE.
    - req_ready is 0 in DONE, so the minimum store-to-store spacing is beats+2 cycles.
- Beat limits:
  - Aligned stores of 1, 2 or 4 bytes always take one beat.
  - An aligned 8-byte store takes 2 beats; a misaligned 8-byte store takes 3.
  - A 2- or 4-byte store crossing a word boundary takes 2 beats.
- Request inputs are ignored outside IDLE, and changing them mid-store has no effect.
- mem_ready while mem_valid=0 is ignored.

Test Plan:
- Aligned byte store: addr=0x1003, size=BITS_8, data=0xFFFF_FFFF_FFFF_FFA5 → 1 beat: mem_addr=0x1000, wdata=0xA5000000, wstrb=4'b1000. done pulses on the cycle after the handshake.
- Crossing word store: addr=0x1002, size=BITS_32, data=0xFFFFFFFF_AABBCCDD → beat0: 0x1000 / 0xCCDD0000 / 4'b1100; beat1: 0x1004 / 0x0000AABB / 4'b0011.
- Misaligned 64-bit store: addr=0x2001, size=BITS_64, data=0x1122334455667788 → beat0: 0x2000 / 0x66778800 / 4'b1110; beat1: 0x2004 / 0x22334455 / 4'b1111; beat2: 0x2008 / 0x00000011 / 4'b0001.
- Backpressure: aligned 64-bit store at 0x3000 with mem_ready low for 3 cycles per beat → beat fields stay stable while stalled. Exactly 2 beats are sent (0x55667788, then 0x11223344, both with wstrb=4'b1111). req_ready stays 0 until after done.
- Reset mid-store: assert reset_n=0 during beat1 of the case above → mem_valid=0 immediately, no done pulse. After release: req_ready=1, and a new BITS_16 store to 0x4000 with data 0xBEEF gives wdata=0x0000BEEF, wstrb=4'b0011.
- Back-to-back: two BITS_16 stores issued with req_valid held high → the second is accepted only in IDLE after the first done pulse. mem_ready held high gives no gaps between beats within a store.
